// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency req/ack
// instruction-memory port and feeds {pc, inst, valid} to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        flush_o,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        unused_low_bits;

    assign target          = {redirect_pc_i[31:2], 2'b00};
    assign pc_inc          = pc_q + 32'd4;
    assign unused_low_bits = ^redirect_pc_i[1:0];

    // Memory handshake: a request is live while imem_req_o=1; imem_addr_o holds
    // steady until the cycle imem_ack_i=1, which may coincide with the first
    // request cycle. HOLD is the only state without a live request. In KILL the
    // stale request is kept at its original address until acked and dropped.
    assign imem_req_o  = !rst_i && (state_q != HOLD);
    assign imem_addr_o = (state_q == KILL) ? kill_addr_q : pc_q;
    assign flush_o     = redirect_i;

    assign pc_o      = out_pc_q;
    assign inst_o    = out_inst_q;
    assign valid_o   = out_valid_q;
    assign fsm_state = state_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_valid_d = out_valid_q;

        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    pc_d        = target;
                    out_valid_d = 1'b0;
                    out_inst_d  = NOP_INST;
                    if (!imem_ack_i) begin
                        state_d     = KILL;
                        kill_addr_d = pc_q;
                    end
                end else if (stall_i) begin
                    // A word arriving under stall is parked until the stall clears.
                    if (imem_ack_i) begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = imem_rdata_i;
                        pc_d       = pc_inc;
                        state_d    = HOLD;
                    end
                end else if (imem_ack_i) begin
                    out_pc_d    = pc_q;
                    out_inst_d  = imem_rdata_i;
                    out_valid_d = 1'b1;
                    pc_d        = pc_inc;
                end else begin
                    out_valid_d = 1'b0;
                    out_inst_d  = NOP_INST;
                end
            end

            HOLD: begin
                // A redirect makes the parked word wrong-path, so it is dropped.
                if (redirect_i) begin
                    pc_d        = target;
                    out_valid_d = 1'b0;
                    out_inst_d  = NOP_INST;
                    state_d     = FETCH;
                end else if (!stall_i) begin
                    out_pc_d    = buf_pc_q;
                    out_inst_d  = buf_inst_q;
                    out_valid_d = 1'b1;
                    state_d     = FETCH;
                end
            end

            KILL: begin
                if (redirect_i) begin
                    pc_d        = target;
                    out_valid_d = 1'b0;
                    out_inst_d  = NOP_INST;
                end
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            kill_addr_q <= RESET_PC;
            buf_pc_q    <= RESET_PC;
            buf_inst_q  <= NOP_INST;
            out_pc_q    <= RESET_PC;
            out_inst_q  <= NOP_INST;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
